// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings, default parameters and counter widths for mem_arbiter
package mem_arb_pkg;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 3;
    localparam int CNT_W          = 3;
    localparam int STARVE_W       = 3;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/arb_lat_cnt.sv
// arb_lat_cnt: loadable latency counter with clear, enable and terminal flag at MEM_LAT-1
// Ports: clk, rst (async active-low), clr (highest priority), ld/ld_val, en, term
module arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             en,
    input  logic [CNT_W-1:0] ld_val,
    output logic             term
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : ld ? ld_val : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign term = cnt_q == CNT_W'(MEM_LAT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between fetch and load/store
// Ports: clk, rst (async active-low); fetch port if_*; data port d_*; memory port mem_*; err
// Optional: define MEM_ARB_ERR_EN to build the sticky protocol checker driving err
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        err
);
    state_t              state_q, state_d;
    owner_t              own_q, own_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [15:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [15:0]         if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic                if_done_q, if_done_d, d_done_q, d_done_d;
    logic                if_ok, d_ok, grant, pick_if, busy, fin, term;

    arb_lat_cnt #(.MEM_LAT(MEM_LAT)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (fin),
        .ld     (grant),
        .en     (busy),
        .ld_val ('0),
        .term   (term)
    );

    always_comb begin
        // a port in its done cycle still holds req; masking it avoids a double grant
        if_ok       = if_req & ~if_done_q;
        d_ok        = d_req & ~d_done_q;
        busy        = state_q == BUSY;
        grant       = ~busy & (if_ok | d_ok);
        pick_if     = if_ok & (~d_ok | (starve_q == STARVE_W'(STARVE_MAX)));
        fin         = busy & term;
        state_d     = grant ? BUSY : fin ? IDLE : state_q;
        own_d       = grant ? (pick_if ? OWN_IF : OWN_D) : own_q;
        starve_d    = !grant ? starve_q : pick_if ? '0 :
                      (if_req && starve_q != '1) ? starve_q + 1'b1 : starve_q;
        mem_en_d    = grant;
        mem_wr_d    = grant ? (~pick_if & d_wr) : fin ? 1'b0 : mem_wr_q;
        mem_addr_d  = grant ? (pick_if ? if_addr : d_addr) : fin ? '0 : mem_addr_q;
        mem_wdata_d = grant ? (pick_if ? '0 : d_wdata) : fin ? '0 : mem_wdata_q;
        if_done_d   = fin & (own_q == OWN_IF);
        d_done_d    = fin & (own_q == OWN_D);
        if_rdata_d  = if_done_d ? mem_rdata : if_rdata_q;
        d_rdata_d   = (d_done_d & ~mem_wr_q) ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            own_q       <= OWN_IF;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    // stalls are forced low while reset is asserted so every output reads 0
    assign if_stall  = rst & if_req & ~if_done_q;
    assign d_stall   = rst & d_req & ~d_done_q;

`ifdef MEM_ARB_ERR_EN
    logic err_q, err_d, d_wr_p_q;
    always_comb begin
        err_d = err_q
              | (grant & (pick_if ? if_addr[0] : d_addr[0]))
              | (busy & ((own_q == OWN_IF) ? ~if_req : ~d_req))
              | (busy & (d_wr != d_wr_p_q));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q    <= 1'b0;
            d_wr_p_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            d_wr_p_q <= d_wr;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port, fixed-latency data memory between the instruction-fetch path and the load/store path of the processor.
- Sequences one transaction at a time: grant, issue, wait for latency, return data.
- Generates the per-port stall signals the pipeline control uses to freeze the PC and the writeback.
- Sits between proc-level fetch/mem logic and a single memory2c-style macro.

Parameters:
MEM_LAT, 1, memory read latency in cycles (1..8); read data is valid on mem_rdata MEM_LAT cycles after the mem_en cycle's start, i.e. during the last BUSY cycle.
STARVE_MAX, 3, consecutive data grants allowed while fetch waits before fetch is forced (1..7).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held until if_done
if_addr  in  16  fetch address (PC)
if_rdata  out  16  fetched instruction, valid when if_done
if_done  out  1  one-cycle completion pulse, fetch port
if_stall  out  1  if_req & ~if_done
d_req  in  1  data request, held until d_done
d_wr  in  1  1=store, 0=load
d_addr  in  16  data address
d_wdata  in  16  store data
d_rdata  out  16  load data, valid when d_done
d_done  out  1  one-cycle completion pulse, data port
d_stall  out  1  d_req & ~d_done
mem_en  out  1  memory enable, one cycle per transaction
mem_wr  out  1  memory write strobe, qualified by mem_en
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- States:
  - IDLE: no transaction.
  - BUSY: one transaction outstanding; owner flag = IF or D.
- Reset (rst=0, async):
  - state=IDLE, latency counter=0, starve=0.
  - All outputs 0, including if_rdata/d_rdata and err.
  - An in-flight transaction is abandoned; no done pulse follows reset release.
- IDLE, posedge with any req and no done pulse for that port this cycle:
  - Grant and latch addr/wr/wdata from the granted port.
  - Go to BUSY, cnt=0.
  - A port whose done is high this cycle is not eligible; this prevents a double grant while req is still high.
- Arbitration:
  - Data wins over fetch.
  - Exception: fetch wins when if_req=1 and starve==STARVE_MAX.
  - starve increments (saturating) on each data grant while if_req=1.
  - starve clears on every fetch grant.
- BUSY:
  - mem_en=1 in the first BUSY cycle only (cnt==0).
  - mem_addr, mem_wr, mem_wdata are driven from the latches for all BUSY cycles; they are 0 in IDLE.
  - cnt increments each cycle.
  - Posedge with cnt==MEM_LAT-1:
    - For a load or fetch, capture mem_rdata into the owner's rdata register.
    - Pulse the owner's done for the next cycle (state IDLE).
  - Stores pulse d_done on the same schedule; d_rdata is unchanged.
- Latency: req sampled at edge k → done high in cycle k+MEM_LAT+1. Back-to-back grants are possible in the done cycle (to the other port, or to the same port after it drops and re-asserts req).
- rdata registers hold their value until the next capture for that port.
- Requests arriving during BUSY wait; stall stays high.
- Simultaneous if_req/d_req in IDLE resolve per the arbitration rule; the loser's stall stays high.

Optional Feature:
Macro MEM_ARB_ERR_EN.
- Defined: err sets (sticky until reset) when any of the following occurs:
  - The owner drops req during BUSY.
  - Granted address bit 0 = 1 (misaligned word).
  - d_wr changes during BUSY.
- Not defined: err is tied 0 and no checking logic is built.
- Transaction behaviour is identical in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1)
  - owner encoding (OWN_IF=1'b0, OWN_D=1'b1)
  - default MEM_LAT and STARVE_MAX
  - counter widths (3 bits each)
- One natural sub-module, arb_lat_cnt: loadable 3-bit latency counter with clear, enable, and a terminal flag at MEM_LAT-1.

Test Plan:
- MEM_LAT=1, single fetch if_addr=16'h0010, mem_rdata=16'hA5A5 → mem_en in cycle 1 only, if_done in cycle 2, if_rdata=16'hA5A5, if_stall high for cycles 0–1.
- Both req in the same cycle, d_wr=1, d_addr=16'h0100, d_wdata=16'h1234 → data granted first, mem_wr=1 with that addr/data; fetch granted in the d_done cycle.
- d_req held continuously with if_req, STARVE_MAX=3 → grant order D,D,D,IF,D,D,D,IF.
- MEM_LAT=4 load → mem_en one cycle, addr stable for 4 cycles, d_done exactly 5 cycles after request edge.
- rst asserted mid-BUSY (MEM_LAT=4, cnt=2) → all outputs 0 immediately; no done after release; next request completes normally.
- With MEM_ARB_ERR_EN: fetch at if_addr=16'h0003 → err=1 and stays 1; without the macro, same stimulus → err=0.
